// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - NZCV flag register, ARM condition evaluation and gated execute-to-memory control register
// Optional feature macro: COND_SQUASH_CNT_EN (builds the saturating squashed-instruction counter)
module cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_e,
    input  logic [3:0]       cond_e,
    input  logic [1:0]       flag_write_e,
    input  logic [3:0]       alu_flags,
    input  logic             reg_write_e,
    input  logic             mem_write_e,
    input  logic             pc_src_e,
    input  logic             stall,
    input  logic             flush,
    output logic             cond_ex_e,
    output logic [3:0]       flags,
    output logic             valid_m,
    output logic             reg_write_m,
    output logic             mem_write_m,
    output logic             pc_src_m,
    output logic [CNT_W-1:0] squash_count
);

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;
    logic cond_true;
    logic commit;
    logic squash;

    assign flag_n = flags[3];
    assign flag_z = flags[2];
    assign flag_c = flags[1];
    assign flag_v = flags[0];

    // Evaluate the condition field against the registered (architectural) flags
    always_comb begin
        cond_true = 1'b1;
        case (cond_e)
            4'b0000: cond_true = flag_z;
            4'b0001: cond_true = ~flag_z;
            4'b0010: cond_true = flag_c;
            4'b0011: cond_true = ~flag_c;
            4'b0100: cond_true = flag_n;
            4'b0101: cond_true = ~flag_n;
            4'b0110: cond_true = flag_v;
            4'b0111: cond_true = ~flag_v;
            4'b1000: cond_true = flag_c & ~flag_z;
            4'b1001: cond_true = ~flag_c | flag_z;
            4'b1010: cond_true = (flag_n == flag_v);
            4'b1011: cond_true = (flag_n != flag_v);
            4'b1100: cond_true = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_true = flag_z | (flag_n != flag_v);
            default: cond_true = 1'b1;
        endcase
    end

    assign cond_ex_e = valid_e & cond_true;
    assign commit    = cond_ex_e & ~stall & ~flush;
    assign squash    = valid_e & ~cond_true & ~stall & ~flush;

    // Flag register: each half is written only by a committing instruction that selects it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (commit) begin
            if (flag_write_e[1]) flags[3:2] <= alu_flags[3:2];
            if (flag_write_e[0]) flags[1:0] <= alu_flags[1:0];
        end
    end

    // Memory-stage register: flush inserts a bubble, stall holds, otherwise load gated controls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_m     <= 1'b0;
            reg_write_m <= 1'b0;
            mem_write_m <= 1'b0;
            pc_src_m    <= 1'b0;
        end else if (flush) begin
            valid_m     <= 1'b0;
            reg_write_m <= 1'b0;
            mem_write_m <= 1'b0;
            pc_src_m    <= 1'b0;
        end else if (!stall) begin
            valid_m     <= valid_e;
            reg_write_m <= reg_write_e & cond_ex_e;
            mem_write_m <= mem_write_e & cond_ex_e;
            pc_src_m    <= pc_src_e & cond_ex_e;
        end
    end

`ifdef COND_SQUASH_CNT_EN
    // Saturating count of valid instructions that failed their condition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            squash_count <= '0;
        end else if (squash && (squash_count != {CNT_W{1'b1}})) begin
            squash_count <= squash_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign squash_count = '0;

    logic unused_squash;
    assign unused_squash = squash;
`endif

endmodule

// File: doc/cond_unit.md
# cond_unit

Condition and flag stage sitting directly downstream of the `alu` in the execute stage. It holds the architectural NZCV flag register and evaluates the 4-bit ARM condition field against it. It gates the register-write, memory-write and PC-source controls of the executing instruction, updates flags from `alu_flags` when the instruction both passes and requests it, and registers the gated controls into the memory stage.

## Interface
Parameters:
- CNT_W, 16, width of the saturating squashed-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- valid_e  in  1  execute-stage instruction valid
- cond_e  in  4  ARM condition field of the execute instruction
- flag_write_e  in  2  [1]: write N,Z; [0]: write C,V
- alu_flags  in  4  {N,Z,C,V} from the ALU, same cycle
- reg_write_e, mem_write_e, pc_src_e  in  1 each  ungated decoder controls
- stall  in  1  hold the memory-stage register; suppress all state updates
- flush  in  1  kill the execute instruction (bubble into memory stage)
- cond_ex_e  out  1  combinational condition-pass for the execute instruction
- flags  out  4  architectural {N,Z,C,V} register
- valid_m, reg_write_m, mem_write_m, pc_src_m  out  1 each  registered gated controls
- squash_count  out  CNT_W  count of valid instructions that failed their condition

## Operation
- Condition evaluation uses the registered `flags`, not `alu_flags`:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 is treated as 1
- cond_ex_e = valid_e & cond_true; purely combinational.
- commit = cond_ex_e & ~stall & ~flush.
- Flag update on commit:
  - flags[3:2] <= alu_flags[3:2] if flag_write_e[1]
  - flags[1:0] <= alu_flags[1:0] if flag_write_e[0]
  - unselected halves hold their value
- Memory-stage register, priority flush > stall > load:
  - flush: all four _m outputs <= 0
  - stall: all four _m outputs hold
  - else: valid_m <= valid_e; each control_m <= control_e & cond_ex_e
- squash_count increments when valid_e & ~cond_true & ~stall & ~flush. It saturates at 2^CNT_W-1 and never wraps.
- A failing instruction still advances (valid_m = 1) but all of its controls are 0.

## Timing
- Reset (asynchronous, immediate): flags = 4'b0000, valid_m/reg_write_m/mem_write_m/pc_src_m = 0, squash_count = 0.
- cond_ex_e has zero latency from cond_e/valid_e and from `flags`.
- A flag write is visible to the next cycle's execute instruction (one-cycle latency), so back-to-back flag-set then conditional execution needs no stall.
- Gated controls appear on the _m outputs one cycle after the execute cycle.
- Simultaneous stall and flush: flush wins; flags and the counter do not update.
- Reset asserted mid-operation clears state regardless of stall or flush; the first edge after deassertion behaves normally.
- An instruction with valid_e = 0 never writes flags or counts, whatever its other inputs.

## Configuration
- COND_SQUASH_CNT_EN:
  - Defined: squash_count is implemented as specified.
  - Undefined: no counter flops are built and squash_count is tied to 0. All other behaviour is identical.

## Test plan
- Reset mid-stream with flags = 4'b1111 and _m = 1 → all outputs 0 immediately, before the next clock edge.
- flags = 0000, cond_e = 0000 (EQ), reg_write_e = 1, flag_write_e = 2'b10, alu_flags = 0100 → cond_ex_e = 0, reg_write_m = 0, flags stay 0000, squash_count = 1 (with the macro).
- Cycle 1: AL, flag_write_e = 2'b11, alu_flags = 1001. Cycle 2: cond_e = 1010 (GE), mem_write_e = 1 → cycle 2 cond_ex_e = 1, mem_write_m = 1 at cycle 3, flags = 1001.
- flag_write_e = 2'b01 with flags = 1100 and alu_flags = 0011 → flags = 1111; a following cond HI → 0 and LS → 1.
- stall = 1 and flush = 1 together with AL, flag_write_e = 11 → _m = 0, flags unchanged. stall alone → _m holds its previous values.
- CNT_W = 2 with 5 consecutive failing valid instructions → squash_count = 3 (saturated). With the macro undefined → squash_count stays 0.
